// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor and the branching unit.
// Holds the branching-unit decision encodings, the 2-bit predictor counter
// states and small arithmetic helpers used by the predictor datapath.
package branch_predictor_pkg;

  localparam int unsigned XLEN = 32;

  // Decision reported by the branching unit for the instruction in execute.
  typedef enum logic [1:0] {
    DEC_NOT_TAKEN  = 2'b00,
    DEC_BR_TAKEN   = 2'b01,
    DEC_JALR_TAKEN = 2'b10,
    DEC_RSVD       = 2'b11
  } decision_e;

  // 2-bit saturating predictor counter states.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state logic.
// Ports:
//   state - current counter state
//   taken - resolved direction of the branch
//   next  - counter state after training with 'taken'
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  ctr_e state,
  input  logic taken,
  output ctr_e next
);

  always_comb begin
    next = state;
    if (taken) begin
      if (state != CTR_ST) next = ctr_e'(state + 2'd1);
    end else begin
      if (state != CTR_SNT) next = ctr_e'(state - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   f_pc                 - fetch PC to look up
//   pred_taken/_target   - combinational prediction for f_pc
//   ex_*                 - resolved instruction from execute (training input)
//   mispredict           - registered one-cycle redirect pulse
//   redirect_pc          - correct next PC while mispredict is high
//   br_count, mp_count   - saturating resolved-transfer / misprediction counts
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     f_pc,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  input  logic            ex_valid,
  input  logic [31:0]     ex_pc,
  input  logic            ex_B,
  input  logic            ex_jump,
  input  logic [1:0]      ex_decision,
  input  logic [31:0]     ex_target,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_target,
  output logic            mispredict,
  output logic [31:0]     redirect_pc,
  output logic [31:0]     br_count,
  output logic [31:0]     mp_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  ctr_e             ctr_q    [ENTRIES];
  ctr_e             ctr_d    [ENTRIES];

  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mp_count_q, mp_count_d;

  // Fetch-side lookup reads registered state only, so a same-cycle update
  // to the same index becomes visible one cycle later.
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  ctr_e             f_ctr;

  always_comb begin
    f_idx       = f_pc[IDX_W+1:2];
    f_tag       = f_pc[31:IDX_W+2];
    f_ctr       = ctr_q[f_idx];
    f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = f_hit && f_ctr[1];
    pred_target = pred_taken ? target_q[f_idx] : pc_plus4(f_pc);
  end

  // Execute-side training.
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  ctr_e             ex_ctr;
  ctr_e             ex_ctr_next;
  decision_e        ex_dec;
  logic             rct;
  logic             actual_taken;
  logic             mp_now;

  always_comb begin
    ex_idx       = ex_pc[IDX_W+1:2];
    ex_tag       = ex_pc[31:IDX_W+2];
    ex_ctr       = ctr_q[ex_idx];
    ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_dec       = decision_e'(ex_decision);
    // The reserved decision code is treated as no resolved transfer at all.
    rct          = ex_valid && (ex_B || ex_jump) && (ex_dec != DEC_RSVD);
    actual_taken = (ex_dec != DEC_NOT_TAKEN);
    mp_now       = rct && ((actual_taken != ex_pred_taken) ||
                           (actual_taken && (ex_pred_target != ex_target)));
  end

  sat_counter2 u_sat_counter2 (
    .state (ex_ctr),
    .taken (actual_taken),
    .next  (ex_ctr_next)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (rct) begin
      if (ex_hit) begin
        ctr_d[ex_idx] = ex_jump ? CTR_ST : ex_ctr_next;
        if (actual_taken) target_d[ex_idx] = ex_target;
      end else if (actual_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = ex_jump ? CTR_ST : CTR_WT;
      end
    end

    mispredict_d  = mp_now;
    redirect_pc_d = redirect_pc_q;
    if (mp_now) redirect_pc_d = actual_taken ? ex_target : pc_plus4(ex_pc);
    br_count_d = rct    ? sat_inc(br_count_q) : br_count_q;
    mp_count_d = mp_now ? sat_inc(mp_count_q) : mp_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '{default: 1'b0};
      tag_q         <= '{default: '0};
      target_q      <= '{default: '0};
      ctr_q         <= '{default: CTR_WNT};
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      br_count_q    <= '0;
      mp_count_q    <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      br_count_q    <= br_count_d;
      mp_count_q    <= mp_count_d;
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign br_count    = br_count_q;
  assign mp_count    = mp_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_B;
  logic        ex_jump;
  logic [1:0]  ex_decision;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  int vectors;
  int miscompares;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .f_pc           (f_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_B           (ex_B),
    .ex_jump        (ex_jump),
    .ex_decision    (ex_decision),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mp_count       (mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ex_drive(input logic v, input logic [31:0] pc, input logic b, input logic j,
                          input logic [1:0] dec, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_B = b; ex_jump = j; ex_decision = dec;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic ex_idle();
    ex_drive(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_idle(); f_pc = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL rst_pred_taken got=%0h exp=0", pred_taken); end
    vectors++; if (pred_target !== 32'h104) begin miscompares++; $display("FAIL rst_pred_target got=%0h exp=104", pred_target); end
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL rst_mispredict got=%0h exp=0", mispredict); end
    vectors++; if (br_count !== 32'd0) begin miscompares++; $display("FAIL rst_br_count got=%0d exp=0", br_count); end
    vectors++; if (mp_count !== 32'd0) begin miscompares++; $display("FAIL rst_mp_count got=%0d exp=0", mp_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_allocate();
    @(negedge clk);
    ex_drive(1'b1, 32'h100, 1'b1, 1'b0, 2'b01, 32'h80, 1'b0, 32'h104);
    f_pc = 32'h100;
    #1;
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL alloc_same_cycle_taken got=%0h exp=0", pred_taken); end
    @(negedge clk); ex_idle(); #1;
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL alloc_mispredict got=%0h exp=1", mispredict); end
    vectors++; if (redirect_pc !== 32'h80) begin miscompares++; $display("FAIL alloc_redirect got=%0h exp=80", redirect_pc); end
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL alloc_pred_taken got=%0h exp=1", pred_taken); end
    vectors++; if (pred_target !== 32'h80) begin miscompares++; $display("FAIL alloc_pred_target got=%0h exp=80", pred_target); end
    vectors++; if (br_count !== 32'd1) begin miscompares++; $display("FAIL alloc_br_count got=%0d exp=1", br_count); end
    vectors++; if (mp_count !== 32'd1) begin miscompares++; $display("FAIL alloc_mp_count got=%0d exp=1", mp_count); end
    @(negedge clk); #1;
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL alloc_pulse_width got=%0h exp=0", mispredict); end
  endtask

  // Entry for 0x100 starts at WT; walk it down to SNT and back up.
  task automatic test_train();
    @(negedge clk);
    ex_drive(1'b1, 32'h100, 1'b1, 1'b0, 2'b00, 32'h80, 1'b1, 32'h80);
    f_pc = 32'h100; #1;
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL nt1_pre_update got=%0h exp=1", pred_taken); end
    @(negedge clk); ex_idle(); #1;
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL nt1_mispredict got=%0h exp=1", mispredict); end
    vectors++; if (redirect_pc !== 32'h104) begin miscompares++; $display("FAIL nt1_redirect got=%0h exp=104", redirect_pc); end
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL nt1_pred_taken got=%0h exp=0", pred_taken); end
    vectors++; if (pred_target !== 32'h104) begin miscompares++; $display("FAIL nt1_pred_target got=%0h exp=104", pred_target); end
    @(negedge clk);
    ex_drive(1'b1, 32'h100, 1'b1, 1'b0, 2'b00, 32'h80, 1'b0, 32'h104);
    @(negedge clk); ex_idle(); #1;
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL nt2_mispredict got=%0h exp=0", mispredict); end
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL nt2_pred_taken got=%0h exp=0", pred_taken); end
    vectors++; if (br_count !== 32'd3) begin miscompares++; $display("FAIL nt2_br_count got=%0d exp=3", br_count); end
    vectors++; if (mp_count !== 32'd2) begin miscompares++; $display("FAIL nt2_mp_count got=%0d exp=2", mp_count); end
    // From SNT one taken only reaches WNT: still predicts not taken.
    @(negedge clk);
    ex_drive(1'b1, 32'h100, 1'b1, 1'b0, 2'b01, 32'h90, 1'b0, 32'h104);
    @(negedge clk); ex_idle(); #1;
    vectors++; if (redirect_pc !== 32'h90) begin miscompares++; $display("FAIL t1_redirect got=%0h exp=90", redirect_pc); end
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL t1_pred_taken got=%0h exp=0", pred_taken); end
    @(negedge clk);
    ex_drive(1'b1, 32'h100, 1'b1, 1'b0, 2'b01, 32'h90, 1'b0, 32'h104);
    @(negedge clk); ex_idle(); #1;
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL t2_pred_taken got=%0h exp=1", pred_taken); end
    vectors++; if (pred_target !== 32'h90) begin miscompares++; $display("FAIL t2_pred_target got=%0h exp=90", pred_target); end
    vectors++; if (br_count !== 32'd5) begin miscompares++; $display("FAIL t2_br_count got=%0d exp=5", br_count); end
    vectors++; if (mp_count !== 32'd4) begin miscompares++; $display("FAIL t2_mp_count got=%0d exp=4", mp_count); end
  endtask

  task automatic test_jal();
    @(negedge clk);
    ex_drive(1'b1, 32'h200, 1'b0, 1'b1, 2'b01, 32'h400, 1'b0, 32'h204);
    f_pc = 32'h200; #1;
    vectors++; if (pred_target !== 32'h204) begin miscompares++; $display("FAIL jal_same_cycle_target got=%0h exp=204", pred_target); end
    @(negedge clk); ex_idle(); #1;
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL jal_pred_taken got=%0h exp=1", pred_taken); end
    vectors++; if (pred_target !== 32'h400) begin miscompares++; $display("FAIL jal_pred_target got=%0h exp=400", pred_target); end
    vectors++; if (redirect_pc !== 32'h400) begin miscompares++; $display("FAIL jal_redirect got=%0h exp=400", redirect_pc); end
    // Allocated at ST, so one not-taken only drops to WT and keeps predicting taken.
    @(negedge clk);
    ex_drive(1'b1, 32'h200, 1'b1, 1'b0, 2'b00, 32'h400, 1'b1, 32'h400);
    @(negedge clk); ex_idle(); #1;
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL jal_ctr_st got=%0h exp=1", pred_taken); end
    vectors++; if (redirect_pc !== 32'h204) begin miscompares++; $display("FAIL jal_nt_redirect got=%0h exp=204", redirect_pc); end
    vectors++; if (mp_count !== 32'd6) begin miscompares++; $display("FAIL jal_mp_count got=%0d exp=6", mp_count); end
  endtask

  task automatic test_alias();
    @(negedge clk);
    ex_drive(1'b1, 32'h100, 1'b1, 1'b0, 2'b01, 32'h80, 1'b0, 32'h104);
    @(negedge clk);
    ex_drive(1'b1, 32'h140, 1'b1, 1'b0, 2'b01, 32'h20, 1'b0, 32'h144);
    @(negedge clk); ex_idle();
    f_pc = 32'h100; #1;
    vectors++; if (pred_target !== 32'h104) begin miscompares++; $display("FAIL alias_100_target got=%0h exp=104", pred_target); end
    f_pc = 32'h140; #1;
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL alias_140_taken got=%0h exp=1", pred_taken); end
    vectors++; if (pred_target !== 32'h20) begin miscompares++; $display("FAIL alias_140_target got=%0h exp=20", pred_target); end
    f_pc = 32'h200; #1;
    vectors++; if (pred_target !== 32'h204) begin miscompares++; $display("FAIL alias_200_target got=%0h exp=204", pred_target); end
    vectors++; if (br_count !== 32'd9) begin miscompares++; $display("FAIL alias_br_count got=%0d exp=9", br_count); end
  endtask

  task automatic test_target_mismatch();
    @(negedge clk);
    ex_drive(1'b1, 32'h140, 1'b0, 1'b1, 2'b10, 32'h20, 1'b1, 32'h20);
    @(negedge clk); ex_idle(); #1;
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL tgt_ok_mispredict got=%0h exp=0", mispredict); end
    @(negedge clk);
    ex_drive(1'b1, 32'h140, 1'b0, 1'b1, 2'b10, 32'h24, 1'b1, 32'h20);
    @(negedge clk); ex_idle(); f_pc = 32'h140; #1;
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL tgt_bad_mispredict got=%0h exp=1", mispredict); end
    vectors++; if (redirect_pc !== 32'h24) begin miscompares++; $display("FAIL tgt_bad_redirect got=%0h exp=24", redirect_pc); end
    vectors++; if (pred_target !== 32'h24) begin miscompares++; $display("FAIL tgt_bad_pred_target got=%0h exp=24", pred_target); end
    vectors++; if (br_count !== 32'd11) begin miscompares++; $display("FAIL tgt_br_count got=%0d exp=11", br_count); end
    vectors++; if (mp_count !== 32'd9) begin miscompares++; $display("FAIL tgt_mp_count got=%0d exp=9", mp_count); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ex_drive(1'b1, 32'h184, 1'b1, 1'b0, 2'b01, 32'h10, 1'b0, 32'h188);
    @(negedge clk);
    ex_drive(1'b1, 32'h188, 1'b1, 1'b0, 2'b01, 32'h30, 1'b0, 32'h18c);
    #1;
    vectors++; if (redirect_pc !== 32'h10) begin miscompares++; $display("FAIL b2b_first_redirect got=%0h exp=10", redirect_pc); end
    @(negedge clk); ex_idle(); #1;
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL b2b_second_mispredict got=%0h exp=1", mispredict); end
    vectors++; if (redirect_pc !== 32'h30) begin miscompares++; $display("FAIL b2b_second_redirect got=%0h exp=30", redirect_pc); end
    @(negedge clk); #1;
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL b2b_drop got=%0h exp=0", mispredict); end
    vectors++; if (mp_count !== 32'd11) begin miscompares++; $display("FAIL b2b_mp_count got=%0d exp=11", mp_count); end
  endtask

  task automatic test_no_update();
    @(negedge clk);
    ex_drive(1'b1, 32'h300, 1'b0, 1'b0, 2'b01, 32'h500, 1'b0, 32'h304);
    @(negedge clk); ex_idle(); f_pc = 32'h300; #1;
    vectors++; if (pred_target !== 32'h304) begin miscompares++; $display("FAIL nocf_pred_target got=%0h exp=304", pred_target); end
    vectors++; if (br_count !== 32'd13) begin miscompares++; $display("FAIL nocf_br_count got=%0d exp=13", br_count); end
    @(negedge clk);
    ex_drive(1'b1, 32'h344, 1'b1, 1'b0, 2'b00, 32'h500, 1'b0, 32'h348);
    @(negedge clk); ex_idle(); f_pc = 32'h344; #1;
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL ntmiss_mispredict got=%0h exp=0", mispredict); end
    vectors++; if (pred_target !== 32'h348) begin miscompares++; $display("FAIL ntmiss_pred_target got=%0h exp=348", pred_target); end
    vectors++; if (br_count !== 32'd14) begin miscompares++; $display("FAIL ntmiss_br_count got=%0d exp=14", br_count); end
    @(negedge clk);
    ex_drive(1'b1, 32'h140, 1'b1, 1'b0, 2'b11, 32'h700, 1'b0, 32'h144);
    @(negedge clk); ex_idle(); f_pc = 32'h140; #1;
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL dec11_mispredict got=%0h exp=0", mispredict); end
    vectors++; if (pred_target !== 32'h24) begin miscompares++; $display("FAIL dec11_pred_target got=%0h exp=24", pred_target); end
    @(negedge clk);
    ex_drive(1'b0, 32'h140, 1'b1, 1'b0, 2'b01, 32'h700, 1'b0, 32'h144);
    @(negedge clk); ex_idle(); #1;
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL novalid_mispredict got=%0h exp=0", mispredict); end
    vectors++; if (pred_target !== 32'h24) begin miscompares++; $display("FAIL novalid_pred_target got=%0h exp=24", pred_target); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ex_drive(1'b1, 32'h140, 1'b1, 1'b0, 2'b01, 32'h700, 1'b0, 32'h144);
    @(posedge clk); #2;
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL mid_pre_mispredict got=%0h exp=1", mispredict); end
    rst_n = 1'b0; #1;
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL mid_mispredict got=%0h exp=0", mispredict); end
    vectors++; if (redirect_pc !== 32'h0) begin miscompares++; $display("FAIL mid_redirect got=%0h exp=0", redirect_pc); end
    vectors++; if (br_count !== 32'd0) begin miscompares++; $display("FAIL mid_br_count got=%0d exp=0", br_count); end
    vectors++; if (mp_count !== 32'd0) begin miscompares++; $display("FAIL mid_mp_count got=%0d exp=0", mp_count); end
    f_pc = 32'h140; #1;
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL mid_140_taken got=%0h exp=0", pred_taken); end
    vectors++; if (pred_target !== 32'h144) begin miscompares++; $display("FAIL mid_140_target got=%0h exp=144", pred_target); end
    f_pc = 32'h184; #1;
    vectors++; if (pred_target !== 32'h188) begin miscompares++; $display("FAIL mid_184_target got=%0h exp=188", pred_target); end
    @(negedge clk); ex_idle(); rst_n = 1'b1;
    @(negedge clk); f_pc = 32'h200; #1;
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL post_rst_taken got=%0h exp=0", pred_taken); end
    vectors++; if (pred_target !== 32'h204) begin miscompares++; $display("FAIL post_rst_target got=%0h exp=204", pred_target); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_allocate();
    test_train();
    test_jal();
    test_alias();
    test_target_mismatch();
    test_back_to_back();
    test_no_update();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
